fifo_flops_thr: RTL and testbench
=================================

// Module: fifo_flops_thr
// PURPOSE
//  Parametrised flop-based synchronous FIFO. Successor of fifo_flops, adding:
//   - programmable almost-full / almost-empty thresholds
//   - occupancy count output and synchronous flush
//   - sticky overflow / underflow error flags
//  Buffer stage between producer/consumer blocks sharing one clock; drop-in superset of fifo_flops ports.
// PARAMETERS
//  depth    16  number of entries, >=2, any integer (not restricted to power of two)
//  bits     8   data width
//  AF_LEVEL 12  almost_full asserted when count >= AF_LEVEL (1..depth)
//  AE_LEVEL 2   almost_empty asserted when count <= AE_LEVEL (0..depth-1)
// PORTS
//  clk          in   1                  clock, all logic on rising edge
//  rst          in   1                  reset, asynchronous, active-low
//  push         in   1                  write request, Din captured when accepted
//  pop          in   1                  read request
//  flush        in   1                  synchronous clear of contents
//  clr_err      in   1                  synchronous clear of sticky error flags
//  Din          in   bits               write data
//  Dout         out  bits               read data
//  full         out  1                  count == depth
//  empty        out  1                  count == 0
//  almost_full  out  1                  count >= AF_LEVEL
//  almost_empty out  1                  count <= AE_LEVEL
//  count        out  $clog2(depth+1)    current occupancy
//  overflow     out  1                  sticky: push rejected while full
//  underflow    out  1                  sticky: pop rejected while empty
// BEHAVIOUR
//  - Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, Dout=0, empty=1, full=0, almost_empty=1,
//    almost_full=0, overflow=underflow=0. Storage array not reset.
//  - Pointers wrap depth-1 -> 0 (explicit compare, no power-of-two masking).
//  - push accepted iff !full || pop_accepted; pop accepted iff !empty. Priority: flush > push/pop.
//  - Full, push+pop: both accepted; count unchanged; write lands in freed slot.
//  - Empty, push+pop: push accepted, pop rejected; underflow set; count -> 1.
//  - Full, push only: data dropped, state unchanged, overflow set.
//  - Empty, pop only: no change, underflow set; Dout holds.
//  - count: +1 push only, -1 pop only, unchanged on both/none; never exceeds depth.
//  - All status flags derived from registered count; all change on the edge that changes count.
//  - flush=1: pointers and count -> 0 next edge; concurrent push/pop ignored (no error flags set).
//  - clr_err=1: clears overflow/underflow; a new error in the same cycle wins (flag stays 1).
//  - Standard mode: Dout registered, loaded with mem[rd_ptr] on the edge accepting pop; holds otherwise.
//    Data pushed at edge N is poppable at edge N+1 (visible on Dout after N+1).
//  - Reset mid-operation: immediate return to reset state, prior contents discarded.
// CONFIGURATION
//  FIFO_FWFT_EN defined:
//   - first-word fall-through; Dout = mem[rd_ptr] combinationally, valid while !empty.
//   - pop acknowledges the head word; the next word appears after that edge.
//   - Dout is don't-care while empty.
//  FIFO_FWFT_EN undefined: standard registered-read mode as in BEHAVIOUR.
//  Flags, count and error logic are identical in both modes.
// TESTING (depth=16, bits=8, AF=12, AE=2)
//  1. Reset, push 0..15 -> almost_full at count 12, full=1 at 16, overflow=0.
//  2. Full, push 0xAA only -> count stays 16, overflow=1.
//     Then clr_err -> overflow=0.
//  3. Pop 16 times (std mode) -> Dout sequence 0..15, empty=1.
//     Extra pop -> underflow=1, Dout holds 15.
//  4. Full, push+pop for 20 cycles -> count stays 16.
//     Output order preserved across pointer wrap; no overflow.
//  5. Empty, push+pop of 0x5C -> count=1, underflow=1.
//     Next pop -> Dout=0x5C.
//  6. 8 pushes, then flush with push=1 -> count=0, empty=1, no error flags.
//     Assert rst=0 mid-burst -> all outputs at reset values same cycle.
//  FWFT build: repeat 3 -> Dout=0 visible before first pop, advances after each pop.

Source files
------------

// File: rtl/fifo_flops_thr_if.sv
// Handshake/status bundle for fifo_flops_thr: the producer/consumer side uses the
// master modport, the FIFO itself uses the slave modport.
interface fifo_flops_thr_if #(
   parameter int depth = 16,
   parameter int bits  = 8
);
   logic                         push;
   logic                         pop;
   logic                         flush;
   logic                         clr_err;
   logic [bits-1:0]              Din;
   logic [bits-1:0]              Dout;
   logic                         full;
   logic                         empty;
   logic                         almost_full;
   logic                         almost_empty;
   logic [$clog2(depth+1)-1:0]   count;
   logic                         overflow;
   logic                         underflow;

   modport master (
      output push, pop, flush, clr_err, Din,
      input  Dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  push, pop, flush, clr_err, Din,
      output Dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_flops_thr.sv
// Flop-based synchronous FIFO with programmable almost-full/empty thresholds, occupancy
// count, flush and sticky error flags. Define FIFO_FWFT_EN for first-word fall-through reads.
module fifo_flops_thr #(
   parameter int depth    = 16,
   parameter int bits     = 8,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 2
) (
   input logic               clk,
   input logic               rst,
   fifo_flops_thr_if.slave   s
);
   localparam int CW = $clog2(depth + 1);
   localparam int PW = (depth > 1) ? $clog2(depth) : 1;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
      return (p == PW'(depth - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [bits-1:0] r_mem [depth];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_overflow;
   logic            r_underflow;

   logic            w_full;
   logic            w_empty;
   logic            w_pop_acc;
   logic            w_push_acc;
   logic            w_ovf_evt;
   logic            w_udf_evt;

   assign w_full     = (r_count == CW'(depth));
   assign w_empty    = (r_count == '0);
   assign w_pop_acc  = s.pop & ~w_empty;
   assign w_push_acc = s.push & (~w_full | w_pop_acc);
   assign w_ovf_evt  = ~s.flush & s.push & ~w_push_acc;
   assign w_udf_evt  = ~s.flush & s.pop & ~w_pop_acc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (s.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push_acc) r_wr_ptr <= f_next_ptr(r_wr_ptr);
            if (w_pop_acc)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
            case ({w_push_acc, w_pop_acc})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
         // A fresh error in the clearing cycle keeps the flag set.
         r_overflow  <= w_ovf_evt | (r_overflow  & ~s.clr_err);
         r_underflow <= w_udf_evt | (r_underflow & ~s.clr_err);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_acc && !s.flush) r_mem[r_wr_ptr] <= s.Din;
   end

`ifdef FIFO_FWFT_EN
   assign s.Dout = r_mem[r_rd_ptr];
`else
   logic [bits-1:0] r_dout;

   // When full with push+pop, the read samples the old word before the write replaces it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dout <= '0;
      end else if (w_pop_acc && !s.flush) begin
         r_dout <= r_mem[r_rd_ptr];
      end
   end

   assign s.Dout = r_dout;
`endif

   assign s.full         = w_full;
   assign s.empty        = w_empty;
   assign s.almost_full  = (r_count >= CW'(AF_LEVEL));
   assign s.almost_empty = (r_count <= CW'(AE_LEVEL));
   assign s.count        = r_count;
   assign s.overflow     = r_overflow;
   assign s.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_flops_thr.sv
// Directed self-checking bench for fifo_flops_thr (depth 16, bits 8, AF 12, AE 2);
// Dout expectations follow the FIFO_FWFT_EN setting of the build.
module tb_fifo_flops_thr;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   fifo_flops_thr_if #(.depth(16), .bits(8)) bus ();

   fifo_flops_thr #(
      .depth(16), .bits(8), .AF_LEVEL(12), .AE_LEVEL(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .s   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock with the given controls; outputs are sampled 1 time unit after the edge.
   task automatic cyc(input logic p, input logic q, input logic f, input logic c,
                      input logic [7:0] d);
      bus.push = p; bus.pop = q; bus.flush = f; bus.clr_err = c; bus.Din = d;
      @(posedge clk);
      #1;
      bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
   endtask

   // Pop with a Dout check: head word before the edge in FWFT, registered word after it otherwise.
   task automatic xfer(input logic p, input logic [7:0] d, input logic [7:0] exp,
                       input string tag);
`ifdef FIFO_FWFT_EN
      chk(tag, 32'(bus.Dout), 32'(exp));
      cyc(p, 1'b1, 1'b0, 1'b0, d);
`else
      cyc(p, 1'b1, 1'b0, 1'b0, d);
      chk(tag, 32'(bus.Dout), 32'(exp));
`endif
   endtask

   // Order of words leaving the FIFO in the wrap test: 0x10..0x1F then 0x30..0x43.
   function automatic logic [7:0] wrap_word(input int idx);
      return (idx < 16) ? 8'(8'h10 + idx) : 8'(8'h30 + idx - 16);
   endfunction

   initial begin
      n_chk = 0; n_pass = 0;
      bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0; bus.Din = '0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_ae", 32'(bus.almost_empty), 1);
      chk("rst_af", 32'(bus.almost_full), 0);
      chk("rst_ovf", 32'(bus.overflow), 0);
      chk("rst_udf", 32'(bus.underflow), 0);
`ifndef FIFO_FWFT_EN
      chk("rst_dout", 32'(bus.Dout), 0);
`endif
      rst = 1'b1;

      // Fill 0..15 and watch the thresholds
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
         chk("fill_count", 32'(bus.count), 32'(i + 1));
         chk("fill_af", 32'(bus.almost_full), 32'((i + 1) >= 12));
         chk("fill_ae", 32'(bus.almost_empty), 32'((i + 1) <= 2));
         chk("fill_full", 32'(bus.full), 32'(i == 15));
      end
      chk("fill_ovf", 32'(bus.overflow), 0);

      // Push while full is dropped and flagged
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
      chk("ovf_count", 32'(bus.count), 16);
      chk("ovf_set", 32'(bus.overflow), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("ovf_clr", 32'(bus.overflow), 0);
      chk("ovf_clr_count", 32'(bus.count), 16);

      // Drain in order, then an extra pop on empty
      for (int i = 0; i < 16; i++) begin
         xfer(1'b0, 8'h00, 8'(i), "drain_dout");
         chk("drain_count", 32'(bus.count), 32'(15 - i));
      end
      chk("drain_empty", 32'(bus.empty), 1);
      chk("drain_ae", 32'(bus.almost_empty), 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("udf_set", 32'(bus.underflow), 1);
      chk("udf_count", 32'(bus.count), 0);
`ifndef FIFO_FWFT_EN
      chk("udf_dout_hold", 32'(bus.Dout), 32'h0F);
`endif
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("udf_clr", 32'(bus.underflow), 0);

      // Full with simultaneous push+pop across the pointer wrap
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i));
      for (int k = 0; k < 20; k++) begin
         xfer(1'b1, 8'(8'h30 + k), wrap_word(k), "wrap_dout");
         chk("wrap_count", 32'(bus.count), 16);
      end
      chk("wrap_ovf", 32'(bus.overflow), 0);
      for (int j = 0; j < 16; j++) xfer(1'b0, 8'h00, wrap_word(20 + j), "wrap_tail");
      chk("wrap_empty", 32'(bus.empty), 1);

      // Push+pop on empty: push wins, pop flagged
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h5C);
      chk("e_pp_count", 32'(bus.count), 1);
      chk("e_pp_udf", 32'(bus.underflow), 1);
      xfer(1'b0, 8'h00, 8'h5C, "e_pp_dout");
      chk("e_pp_empty", 32'(bus.empty), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      chk("e_pp_clr", 32'(bus.underflow), 0);

      // Flush beats a concurrent push and raises no error
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h80 + i));
      chk("pre_flush_count", 32'(bus.count), 8);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
      chk("flush_count", 32'(bus.count), 0);
      chk("flush_empty", 32'(bus.empty), 1);
      chk("flush_ovf", 32'(bus.overflow), 0);
      chk("flush_udf", 32'(bus.underflow), 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
      xfer(1'b0, 8'h00, 8'h77, "post_flush_dout");

      // Asynchronous reset in the middle of a burst
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("pre_rst_count", 32'(bus.count), 4);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_count", 32'(bus.count), 0);
      chk("arst_empty", 32'(bus.empty), 1);
      chk("arst_full", 32'(bus.full), 0);
      chk("arst_ae", 32'(bus.almost_empty), 1);
      chk("arst_af", 32'(bus.almost_full), 0);
`ifndef FIFO_FWFT_EN
      chk("arst_dout", 32'(bus.Dout), 0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
      chk("post_rst_count", 32'(bus.count), 1);
      xfer(1'b0, 8'h00, 8'h99, "post_rst_dout");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
